// File: rtl/axi_bresp_router.sv
// -----------------------------------------------------------------------------
// axi_bresp_router
//
// Purpose:
//   Write-response (B channel) return path for the weighted round-robin AW
//   arbiter. A single slave returns B responses in the order it accepted AW
//   transactions. On every accepted AW handshake this block records the index
//   of the winning master in a small order FIFO. The FIFO head then steers the
//   next B response back to that master. AXI IDs are not tracked.
//
// Parameters:
//   MST_NUM  number of masters (width of aw_grant and the per-master B vectors)
//   DEPTH    maximum outstanding writes; power of two, >= 2
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   aw_grant     one-hot arbiter grant, only looked at when aw_fire = 1
//   aw_fire      slave-side AW handshake this cycle
//   aw_stall     order FIFO full; the AW mux must keep awvalid low
//   s_bvalid     slave B valid
//   s_bready     slave B ready (routed from the head master's m_bready)
//   s_bresp      slave B response
//   m_bvalid     per-master B valid; at most one bit set
//   m_bready     per-master B ready
//   m_bresp      per-master B response; master k uses bits [2k+1:2k]
//   outstanding  registered FIFO occupancy, 0..DEPTH
//   err_grant    one-cycle registered pulse when aw_fire carries a zero or
//                multi-hot grant, or arrives while the FIFO is full
// -----------------------------------------------------------------------------
module axi_bresp_router #(
  parameter int unsigned MST_NUM = 8,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MST_NUM-1:0]           aw_grant,
  input  logic                         aw_fire,
  output logic                         aw_stall,
  input  logic                         s_bvalid,
  output logic                         s_bready,
  input  logic [1:0]                   s_bresp,
  output logic [MST_NUM-1:0]           m_bvalid,
  input  logic [MST_NUM-1:0]           m_bready,
  output logic [2*MST_NUM-1:0]         m_bresp,
  output logic [$clog2(DEPTH):0]       outstanding,
  output logic                         err_grant
);

  // Width of a stored master index. A single master still needs one bit.
  localparam int unsigned IDX_W = (MST_NUM > 1) ? $clog2(MST_NUM) : 1;
  // Address bits of the FIFO; the pointers carry one extra wrap-flag bit.
  localparam int unsigned ADR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = ADR_W + 1;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // True when exactly one grant bit is set.
  function automatic logic is_onehot(input logic [MST_NUM-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int k = 0; k < MST_NUM; k++) begin
      if (vec[k]) begin
        cnt = cnt + 1;
      end else begin
        cnt = cnt;
      end
    end
    return (cnt == 1);
  endfunction

  // Index of the lowest set bit; only meaningful for a one-hot vector.
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [MST_NUM-1:0] vec);
    logic [IDX_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < MST_NUM; k++) begin
      if (vec[k] && !found) begin
        idx   = IDX_W'(k);
        found = 1'b1;
      end else begin
        idx   = idx;
      end
    end
    return idx;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] cnt_q,    cnt_d;
  logic             err_q,    err_d;

  logic             full;
  logic             empty;
  logic             grant_ok;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] head;
  logic             head_ready;

  // ---------------------------------------------------------------------------
  // FIFO status and push/pop qualification
  // ---------------------------------------------------------------------------

  // Same slot with different wrap flags means the writer lapped the reader.
  assign full  = (wr_ptr_q[ADR_W-1:0] == rd_ptr_q[ADR_W-1:0]) &&
                 (wr_ptr_q[ADR_W]     != rd_ptr_q[ADR_W]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign grant_ok = is_onehot(aw_grant);
  assign push     = aw_fire & ~full & grant_ok;
  // s_bready already contains !empty, so a pop can never underflow.
  assign pop      = s_bvalid & s_bready;

  assign head = fifo_q[rd_ptr_q[ADR_W-1:0]];

  assign aw_stall = full;

  // ---------------------------------------------------------------------------
  // B routing: purely combinational, steered by the FIFO head
  // ---------------------------------------------------------------------------

  // Decode the head index into the per-master valid and select its ready.
  // Comparing against every index keeps stale/out-of-range codes harmless.
  always_comb begin
    m_bvalid   = '0;
    head_ready = 1'b0;
    for (int k = 0; k < MST_NUM; k++) begin
      if (head == IDX_W'(k)) begin
        m_bvalid[k] = s_bvalid & ~empty;
        head_ready  = m_bready[k];
      end else begin
        m_bvalid[k] = 1'b0;
      end
    end
  end

  assign s_bready = ~empty & head_ready;

  // The response is broadcast; only the slice whose valid is high matters.
  assign m_bresp = {MST_NUM{s_bresp}};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Pointer, occupancy and error-pulse next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (push) begin
      // Natural PTR_W-bit overflow wraps the slot bits and toggles the flag.
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + PTR_W'(1);
      2'b01:   cnt_d = cnt_q - PTR_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Any AW handshake we refuse to record is flagged: bad grant or overflow.
    err_d = aw_fire & (full | ~grant_ok);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Pointers, occupancy, error pulse and FIFO storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (push) begin
        fifo_q[wr_ptr_q[ADR_W-1:0]] <= onehot_idx(aw_grant);
      end
    end
  end

  assign outstanding = cnt_q;
  assign err_grant   = err_q;

endmodule
